// File: rtl/cpu_pkg.sv
// Shared pipeline encodings for the writeback stage and its forwarding logic.
package cpu_pkg;

  localparam int ZERO_REG = 31;

  typedef enum logic [1:0] {
    WB_ALU  = 2'b00,
    WB_MEM  = 2'b01,
    WB_LINK = 2'b10,
    WB_RSVD = 2'b11
  } wb_sel_t;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

endpackage

// File: rtl/fwd_compare.sv
// Forwarding select for one EX source operand; MEM result beats WB result (younger).
module fwd_compare
  import cpu_pkg::*;
#(
  parameter int ADDR_W   = 5,
  parameter int ZERO_IDX = ZERO_REG
) (
  input  logic [ADDR_W-1:0] rs_i,
  input  logic              mem_valid_i,
  input  logic              mem_regwrite_i,
  input  logic [1:0]        mem_wbsel_i,
  input  logic [ADDR_W-1:0] mem_rd_i,
  input  logic              wb_regwrite_i,
  input  logic [ADDR_W-1:0] wb_rd_i,
  output logic [1:0]        fwd_o
);

  logic mem_hit;
  logic wb_hit;

  // Loads in MEM have no data yet; the hazard unit stalls instead of bypassing.
  assign mem_hit = mem_valid_i & mem_regwrite_i & (mem_rd_i == rs_i) &
                   (rs_i != ADDR_W'(ZERO_IDX)) & (mem_wbsel_i != WB_MEM);
  assign wb_hit  = wb_regwrite_i & (wb_rd_i == rs_i);

  always_comb begin
    fwd_o = FWD_RF;
    if (mem_hit) begin
      fwd_o = FWD_MEM;
    end else if (wb_hit) begin
      fwd_o = FWD_WB;
    end
  end

endmodule

// File: rtl/writeback_stage.sv
// MEM/WB pipeline register, writeback select, retire counter and EX forwarding selects.
module writeback_stage #(
  parameter int DATA_W   = 64,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = cpu_pkg::ZERO_REG,
  parameter int CNT_W    = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              mem_valid,
  input  logic              mem_RegWrite,
  input  logic [1:0]        mem_WbSel,
  input  logic [ADDR_W-1:0] mem_Rd,
  input  logic [DATA_W-1:0] mem_ALUResult,
  input  logic [DATA_W-1:0] mem_ReadData,
  input  logic [DATA_W-1:0] mem_PCPlus4,
  input  logic              wb_stall,
  input  logic              wb_flush,
  input  logic [ADDR_W-1:0] ex_Rn,
  input  logic [ADDR_W-1:0] ex_Rm,
  output logic [DATA_W-1:0] WriteData,
  output logic [ADDR_W-1:0] WriteRegister,
  output logic              RegWrite,
  output logic [1:0]        fwdA,
  output logic [1:0]        fwdB,
  output logic [CNT_W-1:0]  retire_cnt
);
  import cpu_pkg::*;

  logic              valid_q, valid_d;
  logic              regwrite_q, regwrite_d;
  logic [ADDR_W-1:0] rd_q, rd_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] sel_data;
  logic [1:0]        fwd_a_raw, fwd_b_raw;

  always_comb begin
    case (wb_sel_t'(mem_WbSel))
      WB_MEM:  sel_data = mem_ReadData;
      WB_LINK: sel_data = mem_PCPlus4;
      default: sel_data = mem_ALUResult;
    endcase
  end

  assign RegWrite = valid_q & regwrite_q & (rd_q != ADDR_W'(ZERO_REG));

  always_comb begin
    valid_d    = valid_q;
    regwrite_d = regwrite_q;
    rd_d       = rd_q;
    data_d     = data_q;
    cnt_d      = cnt_q;
    if (!wb_stall) begin
      valid_d    = mem_valid;
      regwrite_d = mem_RegWrite;
      rd_d       = mem_Rd;
      data_d     = sel_data;
      if (RegWrite) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
    // Flush overrides stall so a killed instruction never lingers in WB.
    if (wb_flush) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q    <= 1'b0;
      regwrite_q <= 1'b0;
      rd_q       <= '0;
      data_q     <= '0;
      cnt_q      <= '0;
    end else begin
      valid_q    <= valid_d;
      regwrite_q <= regwrite_d;
      rd_q       <= rd_d;
      data_q     <= data_d;
      cnt_q      <= cnt_d;
    end
  end

  assign WriteData     = data_q;
  assign WriteRegister = rd_q;
  assign retire_cnt    = cnt_q;

  fwd_compare #(.ADDR_W(ADDR_W), .ZERO_IDX(ZERO_REG)) u_fwd_a (
    .rs_i           (ex_Rn),
    .mem_valid_i    (mem_valid),
    .mem_regwrite_i (mem_RegWrite),
    .mem_wbsel_i    (mem_WbSel),
    .mem_rd_i       (mem_Rd),
    .wb_regwrite_i  (RegWrite),
    .wb_rd_i        (rd_q),
    .fwd_o          (fwd_a_raw)
  );

  fwd_compare #(.ADDR_W(ADDR_W), .ZERO_IDX(ZERO_REG)) u_fwd_b (
    .rs_i           (ex_Rm),
    .mem_valid_i    (mem_valid),
    .mem_regwrite_i (mem_RegWrite),
    .mem_wbsel_i    (mem_WbSel),
    .mem_rd_i       (mem_Rd),
    .wb_regwrite_i  (RegWrite),
    .wb_rd_i        (rd_q),
    .fwd_o          (fwd_b_raw)
  );

  // MEM-side inputs may still be live during reset; keep EX on the register file.
  assign fwdA = reset_n ? fwd_a_raw : FWD_RF;
  assign fwdB = reset_n ? fwd_b_raw : FWD_RF;

endmodule

// File: tb/tb_writeback_stage.sv
// Bench for writeback_stage: directed scenarios plus random traffic against a reference model.
module tb_writeback_stage;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        mem_valid, mem_RegWrite, wb_stall, wb_flush;
  logic [1:0]  mem_WbSel;
  logic [4:0]  mem_Rd, ex_Rn, ex_Rm;
  logic [63:0] mem_ALUResult, mem_ReadData, mem_PCPlus4;
  logic [63:0] WriteData, WriteData_s;
  logic [4:0]  WriteRegister, WriteRegister_s;
  logic        RegWrite, RegWrite_s;
  logic [1:0]  fwdA, fwdB, fwdA_s, fwdB_s;
  logic [31:0] retire_cnt;
  logic [2:0]  retire_cnt_s;

  int n_checks = 0;
  int n_errors = 0;

  // Reference state: the instruction currently committed in WB and the retire count.
  logic        m_valid, m_rw;
  logic [4:0]  m_rd;
  logic [63:0] m_data;
  logic [31:0] m_cnt;
  logic [31:0] c0;

  always #5 clk = ~clk;

  writeback_stage dut (
    .clk(clk), .reset_n(reset_n), .mem_valid(mem_valid), .mem_RegWrite(mem_RegWrite),
    .mem_WbSel(mem_WbSel), .mem_Rd(mem_Rd), .mem_ALUResult(mem_ALUResult),
    .mem_ReadData(mem_ReadData), .mem_PCPlus4(mem_PCPlus4), .wb_stall(wb_stall),
    .wb_flush(wb_flush), .ex_Rn(ex_Rn), .ex_Rm(ex_Rm), .WriteData(WriteData),
    .WriteRegister(WriteRegister), .RegWrite(RegWrite), .fwdA(fwdA), .fwdB(fwdB),
    .retire_cnt(retire_cnt)
  );

  writeback_stage #(.CNT_W(3)) dut_s (
    .clk(clk), .reset_n(reset_n), .mem_valid(mem_valid), .mem_RegWrite(mem_RegWrite),
    .mem_WbSel(mem_WbSel), .mem_Rd(mem_Rd), .mem_ALUResult(mem_ALUResult),
    .mem_ReadData(mem_ReadData), .mem_PCPlus4(mem_PCPlus4), .wb_stall(wb_stall),
    .wb_flush(wb_flush), .ex_Rn(ex_Rn), .ex_Rm(ex_Rm), .WriteData(WriteData_s),
    .WriteRegister(WriteRegister_s), .RegWrite(RegWrite_s), .fwdA(fwdA_s), .fwdB(fwdB_s),
    .retire_cnt(retire_cnt_s)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic ref_regwrite();
    return m_valid && m_rw && (m_rd != 5'd31);
  endfunction

  function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
    if (mem_valid && mem_RegWrite && mem_Rd == rs && rs != 5'd31 && mem_WbSel != 2'b01)
      return 2'b10;
    if (ref_regwrite() && m_rd == rs)
      return 2'b01;
    return 2'b00;
  endfunction

  task automatic model_reset();
    m_valid = 1'b0; m_rw = 1'b0; m_rd = '0; m_data = '0; m_cnt = '0;
  endtask

  task automatic set_in(input logic v, input logic rw, input logic [1:0] sel,
                        input logic [4:0] rd, input logic [63:0] alu, input logic [63:0] rdat,
                        input logic [63:0] pc4, input logic st, input logic fl,
                        input logic [4:0] rn, input logic [4:0] rm);
    mem_valid = v; mem_RegWrite = rw; mem_WbSel = sel; mem_Rd = rd;
    mem_ALUResult = alu; mem_ReadData = rdat; mem_PCPlus4 = pc4;
    wb_stall = st; wb_flush = fl; ex_Rn = rn; ex_Rm = rm;
  endtask

  task automatic check_outputs();
    chk("RegWrite", 64'(RegWrite), 64'(ref_regwrite()));
    chk("WriteRegister", 64'(WriteRegister), 64'(m_rd));
    chk("WriteData", WriteData, m_data);
    chk("retire_cnt", 64'(retire_cnt), 64'(m_cnt));
    chk("retire_cnt_narrow", 64'(retire_cnt_s), 64'(m_cnt[2:0]));
  endtask

  // Called at a falling edge with inputs already applied; returns at the next falling edge.
  task automatic step();
    #1;
    chk("fwdA", 64'(fwdA), 64'(ref_fwd(ex_Rn)));
    chk("fwdB", 64'(fwdB), 64'(ref_fwd(ex_Rm)));
    @(posedge clk);
    if (ref_regwrite() && !wb_stall) m_cnt = m_cnt + 32'd1;
    if (!wb_stall) begin
      m_rw = mem_RegWrite;
      m_rd = mem_Rd;
      case (mem_WbSel)
        2'b01:   m_data = mem_ReadData;
        2'b10:   m_data = mem_PCPlus4;
        default: m_data = mem_ALUResult;
      endcase
    end
    m_valid = wb_flush ? 1'b0 : (wb_stall ? m_valid : mem_valid);
    #1;
    check_outputs();
    @(negedge clk);
  endtask

  function automatic logic [4:0] rand_reg();
    int r;
    r = $urandom_range(0, 9);
    if (r < 8) return 5'(r);
    return (r == 8) ? 5'd30 : 5'd31;
  endfunction

  initial begin
    reset_n = 1'b0;
    model_reset();
    set_in(1, 1, 2'b00, 5'd2, 64'h5, 64'h6, 64'h7, 0, 0, 5'd2, 5'd2);
    repeat (2) @(negedge clk);
    #1;
    chk("rst_fwdA", 64'(fwdA), 64'd0);
    chk("rst_fwdB", 64'(fwdB), 64'd0);
    check_outputs();
    set_in(0, 0, 2'b00, 5'd0, 64'd0, 64'd0, 64'd0, 0, 0, 5'd0, 5'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Basic ALU write with one-cycle latency.
    set_in(1, 1, 2'b00, 5'd5, 64'h1234, 64'hAAAA, 64'hBBBB, 0, 0, 5'd0, 5'd0);
    step();
    chk("t2_wreg", 64'(WriteRegister), 64'd5);
    chk("t2_wdata", WriteData, 64'h1234);
    chk("t2_regwrite", 64'(RegWrite), 64'd1);
    set_in(0, 0, 2'b00, 5'd0, 64'd0, 64'd0, 64'd0, 0, 0, 5'd0, 5'd0);
    step();
    chk("t2_cnt", 64'(retire_cnt), 64'd1);

    // Zero register: never written, never forwarded.
    set_in(1, 1, 2'b00, 5'd31, 64'h77, 64'h0, 64'h0, 0, 0, 5'd31, 5'd0);
    #1 chk("t3_fwdA_mem", 64'(fwdA), 64'd0);
    step();
    chk("t3_regwrite", 64'(RegWrite), 64'd0);
    chk("t3_cnt", 64'(retire_cnt), 64'd1);
    set_in(0, 0, 2'b00, 5'd0, 64'd0, 64'd0, 64'd0, 0, 0, 5'd31, 5'd0);
    #1 chk("t3_fwdA_wb", 64'(fwdA), 64'd0);
    step();

    // Link and load data selection.
    set_in(1, 1, 2'b10, 5'd30, 64'h5, 64'h6, 64'h40, 0, 0, 5'd0, 5'd0);
    step();
    chk("t4_link", WriteData, 64'h40);
    chk("t4_link_rd", 64'(WriteRegister), 64'd30);
    set_in(1, 1, 2'b01, 5'd4, 64'h5, 64'hDEAD, 64'h40, 0, 0, 5'd0, 5'd0);
    step();
    chk("t4_load", WriteData, 64'hDEAD);

    // Forwarding priority.
    set_in(1, 1, 2'b00, 5'd3, 64'h11, 64'h0, 64'h0, 0, 0, 5'd0, 5'd0);
    step();
    set_in(1, 1, 2'b00, 5'd3, 64'h22, 64'h0, 64'h0, 0, 0, 5'd3, 5'd3);
    #1 chk("t5_fwdA_mem", 64'(fwdA), 64'd2);
    chk("t5_fwdB_mem", 64'(fwdB), 64'd2);
    step();
    set_in(1, 1, 2'b01, 5'd3, 64'h33, 64'h44, 64'h0, 0, 0, 5'd3, 5'd3);
    #1 chk("t5_fwdA_load", 64'(fwdA), 64'd1);
    chk("t5_fwdB_load", 64'(fwdB), 64'd1);
    step();

    // Stall hold, then stall+flush.
    set_in(1, 1, 2'b00, 5'd9, 64'h99, 64'h0, 64'h0, 0, 0, 5'd0, 5'd0);
    step();
    c0 = m_cnt;
    for (int i = 0; i < 3; i++) begin
      set_in(1, 1, 2'b00, 5'd10, {$urandom, $urandom}, 64'h0, 64'h0, 1, 0, 5'd9, 5'd0);
      step();
      chk("t6_hold_data", WriteData, 64'h99);
      chk("t6_hold_rd", 64'(WriteRegister), 64'd9);
      chk("t6_hold_cnt", 64'(retire_cnt), 64'(c0));
    end
    set_in(1, 1, 2'b00, 5'd10, 64'hA0, 64'h0, 64'h0, 0, 0, 5'd0, 5'd0);
    step();
    chk("t6_release_cnt", 64'(retire_cnt), 64'(c0 + 32'd1));
    set_in(1, 1, 2'b00, 5'd11, 64'hB0, 64'h0, 64'h0, 1, 1, 5'd0, 5'd0);
    step();
    chk("t6_flush_regwrite", 64'(RegWrite), 64'd0);
    chk("t6_flush_cnt", 64'(retire_cnt), 64'(c0 + 32'd1));

    // Reset in the middle of a live write.
    set_in(1, 1, 2'b00, 5'd7, 64'h70, 64'h0, 64'h0, 0, 0, 5'd0, 5'd0);
    step();
    set_in(1, 1, 2'b00, 5'd7, 64'h71, 64'h0, 64'h0, 0, 0, 5'd7, 5'd7);
    #2 reset_n = 1'b0;
    #1;
    chk("t1_regwrite", 64'(RegWrite), 64'd0);
    chk("t1_wdata", WriteData, 64'd0);
    chk("t1_cnt", 64'(retire_cnt), 64'd0);
    chk("t1_fwdA", 64'(fwdA), 64'd0);
    chk("t1_fwdB", 64'(fwdB), 64'd0);
    @(posedge clk);
    @(negedge clk);
    model_reset();
    set_in(0, 0, 2'b00, 5'd0, 64'd0, 64'd0, 64'd0, 0, 0, 5'd0, 5'd0);
    reset_n = 1'b1;
    step();
    chk("t1_post_regwrite", 64'(RegWrite), 64'd0);
    chk("t1_post_cnt", 64'(retire_cnt), 64'd0);

    // Eight retirements wrap the narrow counter.
    for (int i = 0; i < 8; i++) begin
      set_in(1, 1, 2'(i % 4), 5'(i), {$urandom, $urandom}, {$urandom, $urandom},
             {$urandom, $urandom}, 0, 0, 5'(i), 5'(i + 1));
      step();
    end
    set_in(0, 0, 2'b00, 5'd0, 64'd0, 64'd0, 64'd0, 0, 0, 5'd0, 5'd0);
    step();
    chk("wrap_wide", 64'(retire_cnt), 64'd8);
    chk("wrap_narrow", 64'(retire_cnt_s), 64'd0);

    for (int i = 0; i < 400; i++) begin
      set_in(($urandom_range(0, 9) < 8), ($urandom_range(0, 9) < 7), 2'($urandom_range(0, 3)),
             rand_reg(), {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
             ($urandom_range(0, 9) < 2), ($urandom_range(0, 9) < 1), rand_reg(), rand_reg());
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
